// File: rtl/dds_pport_responder.sv
// DDS-side responder for the 8-bit parallel DDS port: decodes address/data pairs into a
// shadow register file, commits shadow to active on IO_update, and drives read data back.
module dds_pport_responder #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  RST_VAL     = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pclk_i,
    input  logic              csb_i,
    input  logic              rwn_i,
    input  logic              ioup_i,
    input  logic [7:0]        pdata_i,
    output logic [7:0]        pdata_o,
    output logic              pdata_oe,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              wr_stb,
    output logic [7:0]        wr_addr,
    output logic [7:0]        wr_data,
    output logic              upd_stb,
    output logic [7:0]        abort_cnt,
    output logic [15:0]       txn_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CHAIN = SYNC_STAGES + 1;

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, DONE} stateT;

    logic [CHAIN-1:0]       pclkSr, csbSr, ioupSr;
    logic [SYNC_STAGES-1:0] rwnSr;
    logic [7:0]             pdataSr [SYNC_STAGES];

    // Synchronisers; the extra flop on the edge-detected lines holds the previous sample
    always_ff @(posedge clk) begin
        if (rst) begin
            pclkSr <= '0;
            csbSr  <= '1;
            ioupSr <= '0;
            rwnSr  <= '0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) pdataSr[i] <= '0;
        end else begin
            pclkSr <= {pclkSr[CHAIN-2:0], pclk_i};
            csbSr  <= {csbSr[CHAIN-2:0], csb_i};
            ioupSr <= {ioupSr[CHAIN-2:0], ioup_i};
            rwnSr  <= {rwnSr[SYNC_STAGES-2:0], rwn_i};
            pdataSr[0] <= pdata_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) pdataSr[i] <= pdataSr[i-1];
        end
    end

    logic       pclkRise, csbRise, csbFall, csbHigh, ioupRise, rwnS;
    logic [7:0] pdataS;

    assign pclkRise = pclkSr[CHAIN-2] & ~pclkSr[CHAIN-1];
    assign csbRise  = csbSr[CHAIN-2] & ~csbSr[CHAIN-1];
    assign csbFall  = ~csbSr[CHAIN-2] & csbSr[CHAIN-1];
    assign csbHigh  = csbSr[CHAIN-2];
    assign ioupRise = ioupSr[CHAIN-2] & ~ioupSr[CHAIN-1];
    assign rwnS     = rwnSr[SYNC_STAGES-1];
    assign pdataS   = pdataSr[SYNC_STAGES-1];

    stateT       stateQ, stateNext;
    logic [7:0]  addrQ, addrNext;
    logic [7:0]  pdataQ, pdataNext;
    logic        oeQ, oeNext;
    logic        wrStbQ, wrStbNext;
    logic [7:0]  wrAddrQ, wrAddrNext, wrDataQ, wrDataNext;
    logic        updStbQ;
    logic [7:0]  abortQ;
    logic [15:0] txnQ;
    logic        shadowWe, txnInc, abortInc;

    logic [7:0] shadowMem [DEPTH];
    logic [7:0] activeMem [DEPTH];

    logic       addrInRange, busInRange;
    logic [7:0] shadowAtAddr, shadowAtBus;

    assign addrInRange  = {1'b0, addrQ} < 9'(DEPTH);
    assign busInRange   = {1'b0, pdataS} < 9'(DEPTH);
    assign shadowAtAddr = addrInRange ? shadowMem[addrQ[ADDR_W-1:0]] : 8'h00;
    assign shadowAtBus  = busInRange ? shadowMem[pdataS[ADDR_W-1:0]] : 8'h00;

    // Next-state and registered-output decode
    always_comb begin
        stateNext  = stateQ;
        addrNext   = addrQ;
        pdataNext  = pdataQ;
        oeNext     = oeQ;
        wrStbNext  = 1'b0;
        wrAddrNext = wrAddrQ;
        wrDataNext = wrDataQ;
        shadowWe   = 1'b0;
        txnInc     = 1'b0;
        abortInc   = 1'b0;
        case (stateQ)
            IDLE: begin
                oeNext = 1'b0;
                if (csbFall) stateNext = ADDR;
            end
            ADDR: begin
                if (csbRise) begin
                    stateNext = IDLE;
                    oeNext    = 1'b0;
                    abortInc  = 1'b1;
                end else if (pclkRise) begin
                    addrNext = pdataS;
                    if (rwnS) begin
                        stateNext = RDATA;
                        oeNext    = 1'b1;
                        pdataNext = shadowAtBus;
                    end else begin
                        stateNext = WDATA;
                    end
                end
            end
            WDATA: begin
                if (csbRise) begin
                    stateNext = IDLE;
                    oeNext    = 1'b0;
                    abortInc  = 1'b1;
                end else if (pclkRise) begin
                    shadowWe   = addrInRange;
                    wrStbNext  = 1'b1;
                    wrAddrNext = addrQ;
                    wrDataNext = pdataS;
                    txnInc     = 1'b1;
                    stateNext  = DONE;
                end
            end
            RDATA: begin
                pdataNext = shadowAtAddr;
                if (csbRise) begin
                    stateNext = IDLE;
                    oeNext    = 1'b0;
                    abortInc  = 1'b1;
                end else if (pclkRise) begin
                    txnInc    = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (csbHigh) begin
                    stateNext = IDLE;
                    oeNext    = 1'b0;
                end
            end
            default: begin
                stateNext = IDLE;
                oeNext    = 1'b0;
            end
        endcase
    end

    // State, outputs and register files; commit copies the pre-write shadow
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= IDLE;
            addrQ   <= '0;
            pdataQ  <= '0;
            oeQ     <= 1'b0;
            wrStbQ  <= 1'b0;
            wrAddrQ <= '0;
            wrDataQ <= '0;
            updStbQ <= 1'b0;
            abortQ  <= '0;
            txnQ    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                shadowMem[i] <= RST_VAL;
                activeMem[i] <= RST_VAL;
            end
        end else begin
            stateQ  <= stateNext;
            addrQ   <= addrNext;
            pdataQ  <= pdataNext;
            oeQ     <= oeNext;
            wrStbQ  <= wrStbNext;
            wrAddrQ <= wrAddrNext;
            wrDataQ <= wrDataNext;
            updStbQ <= ioupRise;
            if (shadowWe) shadowMem[addrQ[ADDR_W-1:0]] <= pdataS;
            if (ioupRise) begin
                for (int i = 0; i < int'(DEPTH); i++) activeMem[i] <= shadowMem[i];
            end
            if (txnInc) txnQ <= txnQ + 16'd1;
            if (abortInc && abortQ != 8'hFF) abortQ <= abortQ + 8'd1;
        end
    end

    // Bus is released combinationally so reset frees it without waiting for an edge
    assign pdata_oe  = oeQ & ~rst;
    assign pdata_o   = pdataQ;
    assign rd_data   = activeMem[rd_addr];
    assign wr_stb    = wrStbQ;
    assign wr_addr   = wrAddrQ;
    assign wr_data   = wrDataQ;
    assign upd_stb   = updStbQ;
    assign abort_cnt = abortQ;
    assign txn_cnt   = txnQ;

endmodule

// File: tb/tb_dds_pport_responder.sv
// Directed bench for dds_pport_responder: drives bus frames slowly relative to clk and
// checks registered outputs, strobes and register-file contents against hand-computed values.
module tb_dds_pport_responder;

    logic        clk = 1'b0;
    logic        rst, pclk_i, csb_i, rwn_i, ioup_i;
    logic [7:0]  pdata_i;
    logic [7:0]  pdata_o;
    logic        pdata_oe;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        wr_stb, upd_stb;
    logic [7:0]  wr_addr, wr_data, abort_cnt;
    logic [15:0] txn_cnt;

    int passed = 0;
    int total  = 0;
    int wrPulses = 0;
    int updPulses = 0;

    dds_pport_responder dut (
        .clk(clk), .rst(rst), .pclk_i(pclk_i), .csb_i(csb_i), .rwn_i(rwn_i),
        .ioup_i(ioup_i), .pdata_i(pdata_i), .pdata_o(pdata_o), .pdata_oe(pdata_oe),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_stb(wr_stb), .wr_addr(wr_addr),
        .wr_data(wr_data), .upd_stb(upd_stb), .abort_cnt(abort_cnt), .txn_cnt(txn_cnt)
    );

    always #5 clk = ~clk;

    // Strobe-high cycle counters: a correct single-cycle pulse adds exactly one
    always @(posedge clk) begin
        if (wr_stb)  wrPulses  <= wrPulses + 1;
        if (upd_stb) updPulses <= updPulses + 1;
    end

    task automatic waitN(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic csbLow();
        csb_i = 1'b0;
        waitN(8);
    endtask

    task automatic csbHigh();
        csb_i = 1'b1;
        waitN(8);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic rw, input logic withUp);
        pdata_i = b;
        rwn_i   = rw;
        waitN(4);
        pclk_i = 1'b1;
        if (withUp) ioup_i = 1'b1;
        waitN(8);
        pclk_i = 1'b0;
        waitN(4);
        ioup_i = 1'b0;
    endtask

    task automatic ioupPulse();
        ioup_i = 1'b1;
        waitN(8);
        ioup_i = 1'b0;
        waitN(8);
    endtask

    task automatic writeFrame(input logic [7:0] a, input logic [7:0] d);
        csbLow();
        sendByte(a, 1'b0, 1'b0);
        sendByte(d, 1'b0, 1'b0);
        csbHigh();
    endtask

    initial begin
        rst = 1'b1; pclk_i = 1'b0; csb_i = 1'b1; rwn_i = 1'b0; ioup_i = 1'b0;
        pdata_i = 8'h00; rd_addr = 5'h0c;
        waitN(4);
        rst = 1'b0;
        waitN(4);

        // Reset state
        chk("rst_oe", 16'(pdata_oe), 16'h0);
        chk("rst_pdata_o", 16'(pdata_o), 16'h00);
        chk("rst_abort", 16'(abort_cnt), 16'h00);
        chk("rst_txn", txn_cnt, 16'h0000);
        chk("rst_wr_addr", 16'(wr_addr), 16'h00);
        chk("rst_active", 16'(rd_data), 16'h00);

        // Write 0x0c=0xd0, active only changes on commit
        writeFrame(8'h0c, 8'hd0);
        chk("w1_stb", 16'(wrPulses), 16'd1);
        chk("w1_addr", 16'(wr_addr), 16'h0c);
        chk("w1_data", 16'(wr_data), 16'hd0);
        chk("w1_txn", txn_cnt, 16'd1);
        chk("w1_pre_commit", 16'(rd_data), 16'h00);
        ioupPulse();
        chk("w1_upd_stb", 16'(updPulses), 16'd1);
        chk("w1_post_commit", 16'(rd_data), 16'hd0);

        // Write 0x0d=0x41, commit, then read it back on the bus
        writeFrame(8'h0d, 8'h41);
        ioupPulse();
        rd_addr = 5'h0d;
        waitN(1);
        chk("w2_active", 16'(rd_data), 16'h41);
        csbLow();
        chk("rd_oe_before_addr", 16'(pdata_oe), 16'h0);
        sendByte(8'h0d, 1'b1, 1'b0);
        chk("rd_oe", 16'(pdata_oe), 16'h1);
        chk("rd_data_bus", 16'(pdata_o), 16'h41);
        sendByte(8'h00, 1'b1, 1'b0);
        chk("rd_oe_hold", 16'(pdata_oe), 16'h1);
        chk("rd_txn", txn_cnt, 16'd3);
        csbHigh();
        chk("rd_oe_release", 16'(pdata_oe), 16'h0);

        // Abort after address byte of a write to 0x0c
        csbLow();
        sendByte(8'h0c, 1'b0, 1'b0);
        csbHigh();
        chk("ab_cnt", 16'(abort_cnt), 16'd1);
        chk("ab_txn", txn_cnt, 16'd3);
        chk("ab_no_stb", 16'(wrPulses), 16'd2);
        ioupPulse();
        rd_addr = 5'h0c;
        waitN(1);
        chk("ab_shadow_kept", 16'(rd_data), 16'hd0);

        // Out-of-range write 0x25 (would alias 0x05) is dropped but strobed
        writeFrame(8'h25, 8'h77);
        chk("oor_stb", 16'(wrPulses), 16'd3);
        chk("oor_addr", 16'(wr_addr), 16'h25);
        chk("oor_data", 16'(wr_data), 16'h77);
        chk("oor_txn", txn_cnt, 16'd4);
        ioupPulse();
        rd_addr = 5'h05;
        waitN(1);
        chk("oor_alias", 16'(rd_data), 16'h00);
        csbLow();
        sendByte(8'h25, 1'b1, 1'b0);
        chk("oor_rd_oe", 16'(pdata_oe), 16'h1);
        chk("oor_rd_bus", 16'(pdata_o), 16'h00);
        sendByte(8'h00, 1'b1, 1'b0);
        csbHigh();
        chk("oor_rd_txn", txn_cnt, 16'd5);

        // Commit coincident with a write landing: active keeps the pre-write shadow
        writeFrame(8'h0c, 8'h34);
        csbLow();
        sendByte(8'h0c, 1'b0, 1'b0);
        sendByte(8'h12, 1'b0, 1'b1);
        csbHigh();
        rd_addr = 5'h0c;
        waitN(1);
        chk("co_active", 16'(rd_data), 16'h34);
        chk("co_txn", txn_cnt, 16'd7);
        ioupPulse();
        chk("co_shadow", 16'(rd_data), 16'h12);

        // Reset in the middle of a read releases the bus immediately
        csbLow();
        sendByte(8'h0c, 1'b1, 1'b0);
        chk("rr_oe_before", 16'(pdata_oe), 16'h1);
        rst = 1'b1;
        #1;
        chk("rr_oe_same_cycle", 16'(pdata_oe), 16'h0);
        waitN(2);
        csb_i = 1'b1;
        waitN(6);
        rst = 1'b0;
        waitN(4);
        chk("rr_txn", txn_cnt, 16'd0);
        chk("rr_abort", 16'(abort_cnt), 16'd0);
        chk("rr_active", 16'(rd_data), 16'h00);
        chk("rr_wr_data", 16'(wr_data), 16'h00);
        ioupPulse();
        chk("rr_shadow", 16'(rd_data), 16'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
